// File: rtl/fifo_pkg.sv
// Shared constants for the synchronous FIFO controller.
package fifo_pkg;

  localparam int FIFO_DW     = 8;
  localparam int FIFO_AW     = 4;
  localparam int FIFO_DEPTH  = 1 << FIFO_AW;
  localparam int FIFO_ATHR   = 2;

endpackage

// File: rtl/fifo_mem.sv
// Synchronous dual-port RAM with registered read port.
// Storage is never cleared; only the output register resets.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DW = FIFO_DW,
  parameter int AW = FIFO_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst)     rdata_q <= '0;
    else if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Synchronous FIFO controller: pointers, flags, count, error pulses.
// Define FIFO_ALMOST_EN to add almost_full/almost_empty outputs.
module sync_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = FIFO_DW,
  parameter int ADDR_WIDTH    = FIFO_AW,
  parameter int ALMOST_THRESH = FIFO_ATHR
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
`ifdef FIFO_ALMOST_EN
  ,
  output logic                  almost_full,
  output logic                  almost_empty
`endif
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int PW    = ADDR_WIDTH + 1;

  typedef logic [ADDR_WIDTH:0] ptr_t;

  localparam ptr_t ONE = PW'(1);

  ptr_t wr_ptr_q, wr_ptr_d;
  ptr_t rd_ptr_q, rd_ptr_d;
  ptr_t count_q, count_d;
  logic empty_q, empty_d;
  logic full_q, full_d;
  logic ovf_q, unf_q, rv_q;
  logic wr_acc, rd_acc;

  // Flags come from the pre-edge state, so no bypass while full/empty.
  always_comb begin
    wr_acc   = wr_en & ~full_q & ~rst;
    rd_acc   = rd_en & ~empty_q & ~rst;
    wr_ptr_d = wr_acc ? wr_ptr_q + ONE : wr_ptr_q;
    rd_ptr_d = rd_acc ? rd_ptr_q + ONE : rd_ptr_q;
    count_d  = count_q;
    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + ONE;
      2'b01:   count_d = count_q - ONE;
      default: count_d = count_q;
    endcase
    empty_d = (wr_ptr_d == rd_ptr_d);
    full_d  = (wr_ptr_d[ADDR_WIDTH-1:0] == rd_ptr_d[ADDR_WIDTH-1:0])
            & (wr_ptr_d[ADDR_WIDTH] != rd_ptr_d[ADDR_WIDTH]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      rv_q     <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      ovf_q    <= wr_en & full_q;
      unf_q    <= rd_en & empty_q;
      rv_q     <= rd_acc;
    end
  end

  fifo_mem #(
    .DW (DATA_WIDTH),
    .AW (ADDR_WIDTH)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc),
    .waddr (wr_ptr_q[ADDR_WIDTH-1:0]),
    .wdata (wr_data),
    .re    (rd_acc),
    .raddr (rd_ptr_q[ADDR_WIDTH-1:0]),
    .rdata (rd_data)
  );

`ifdef FIFO_ALMOST_EN
  localparam ptr_t AF_LVL = PW'(DEPTH - ALMOST_THRESH);
  localparam ptr_t AE_LVL = PW'(ALMOST_THRESH);

  logic afull_q, aempty_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
    end else begin
      afull_q  <= (count_d >= AF_LVL);
      aempty_q <= (count_d <= AE_LVL);
    end
  end

  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
`endif

  assign rd_valid  = rv_q;
  assign full      = full_q;
  assign empty     = empty_q;
  assign count     = count_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed bench for sync_fifo_ctrl: vector table plus
// queue-modelled sequences for fill/drain, wrap and reset.
module tb_sync_fifo_ctrl;
  import fifo_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       rd_en = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid, full, empty, overflow, underflow;
  logic [4:0] count;
`ifdef FIFO_ALMOST_EN
  logic       almost_full, almost_empty;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sync_fifo_ctrl #(
    .DATA_WIDTH    (8),
    .ADDR_WIDTH    (4),
    .ALMOST_THRESH (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
`ifdef FIFO_ALMOST_EN
    ,
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
`endif
  );

  typedef struct {
    logic       rs;
    logic       w;
    logic [7:0] wd;
    logic       r;
    logic [4:0] cnt;
    logic       e;
    logic       f;
    logic       rv;
    logic [7:0] rdv;
    logic       ov;
    logic       un;
  } vec_t;

  vec_t vec [13];

  // Behavioural model for the sequences
  logic [7:0] mq[$];
  logic [7:0] m_last = 8'h00;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic drive(input logic rs, input logic w,
                       input logic [7:0] wd, input logic r);
    rst     = rs;
    wr_en   = w;
    wr_data = wd;
    rd_en   = r;
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic rs, input logic w,
                    input logic [7:0] wd, input logic r);
    int  n;
    logic aw, ar, eov, eun;
    n   = mq.size();
    aw  = w && n < FIFO_DEPTH && !rs;
    ar  = r && n > 0 && !rs;
    eov = w && n == FIFO_DEPTH && !rs;
    eun = r && n == 0 && !rs;
    drive(rs, w, wd, r);
    if (rs) begin
      mq.delete();
      m_last = 8'h00;
    end else begin
      if (ar) m_last = mq.pop_front();
      if (aw) mq.push_back(wd);
    end
    n = mq.size();
    chk("count", 32'(count), 32'(n));
    chk("empty", 32'(empty), 32'(n == 0));
    chk("full", 32'(full), 32'(n == FIFO_DEPTH));
    chk("rd_valid", 32'(rd_valid), 32'(ar));
    chk("rd_data", 32'(rd_data), 32'(m_last));
    chk("overflow", 32'(overflow), 32'(eov));
    chk("underflow", 32'(underflow), 32'(eun));
`ifdef FIFO_ALMOST_EN
    chk("almost_full", 32'(almost_full), 32'(n >= FIFO_DEPTH - 2));
    chk("almost_empty", 32'(almost_empty), 32'(n <= 2));
`endif
  endtask

  initial begin
    vec[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vec[1]  = '{1'b1, 1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vec[2]  = '{1'b0, 1'b1, 8'h11, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vec[3]  = '{1'b0, 1'b1, 8'h22, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vec[4]  = '{1'b0, 1'b1, 8'h33, 1'b1, 5'd2, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0};
    vec[5]  = '{1'b0, 1'b0, 8'h00, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0, 8'h11, 1'b0, 1'b0};
    vec[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 5'd1, 1'b0, 1'b0, 1'b1, 8'h22, 1'b0, 1'b0};
    vec[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 1'b0, 1'b1, 8'h33, 1'b0, 1'b0};
    vec[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 8'h33, 1'b0, 1'b1};
    vec[9]  = '{1'b0, 1'b1, 8'h44, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 8'h33, 1'b0, 1'b1};
    vec[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 8'h33, 1'b0, 1'b0};
    vec[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 1'b0, 1'b1, 8'h44, 1'b0, 1'b0};
    vec[12] = '{1'b1, 1'b1, 8'h55, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};

    for (int i = 0; i < 13; i++) begin
      drive(vec[i].rs, vec[i].w, vec[i].wd, vec[i].r);
      chk($sformatf("v%0d.count", i), 32'(count), 32'(vec[i].cnt));
      chk($sformatf("v%0d.empty", i), 32'(empty), 32'(vec[i].e));
      chk($sformatf("v%0d.full", i), 32'(full), 32'(vec[i].f));
      chk($sformatf("v%0d.rd_valid", i), 32'(rd_valid), 32'(vec[i].rv));
      chk($sformatf("v%0d.rd_data", i), 32'(rd_data), 32'(vec[i].rdv));
      chk($sformatf("v%0d.overflow", i), 32'(overflow), 32'(vec[i].ov));
      chk($sformatf("v%0d.underflow", i), 32'(underflow), 32'(vec[i].un));
    end

    // Fill 0x00..0x0F, overflow, drain in order, underflow
    for (int i = 0; i < 16; i++) op(1'b0, 1'b1, 8'(i), 1'b0);
    op(1'b0, 1'b1, 8'hAA, 1'b0);
    op(1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 16; i++) begin
      op(1'b0, 1'b0, 8'h00, 1'b1);
      chk("drain_order", 32'(rd_data), 32'(i));
    end
    op(1'b0, 1'b0, 8'h00, 1'b1);
    op(1'b0, 1'b0, 8'h00, 1'b0);

    // Five words then 40 simultaneous cycles across several laps
    for (int i = 0; i < 5; i++) op(1'b0, 1'b1, 8'(8'h80 + i), 1'b0);
    for (int i = 0; i < 40; i++) op(1'b0, 1'b1, 8'(8'hC0 + i), 1'b1);

    // Full with simultaneous read: write rejected, read accepted
    for (int i = 0; i < 11; i++) op(1'b0, 1'b1, 8'(8'h60 + i), 1'b0);
    op(1'b0, 1'b1, 8'hEE, 1'b1);
    op(1'b0, 1'b1, 8'h70, 1'b0);

    // Drain to 9 then reset alongside a write
    for (int i = 0; i < 7; i++) op(1'b0, 1'b0, 8'h00, 1'b1);
    chk("pre_reset_count", 32'(count), 32'd9);
    op(1'b1, 1'b1, 8'h99, 1'b0);
    op(1'b0, 1'b0, 8'h00, 1'b1);
    chk("post_reset_underflow", 32'(underflow), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
